// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the selector scan sequencer and its index counter.
package mux_scan_pkg;

   localparam int SEL_W    = 5;
   localparam int DATA_W   = 2;
   localparam int NUM_INP  = 2 ** SEL_W;
   localparam int RES_W    = NUM_INP * DATA_W;
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

   typedef logic [SEL_W-1:0]    sel_t;
   typedef logic [DATA_W-1:0]   lane_t;
   typedef logic [SEL_W:0]      cnt_t;
   typedef logic [SETTLE_W-1:0] settle_t;

endpackage

// File: rtl/mux_scan_index_ctr.sv
// Wrapping select index with load/increment, plus the latched last index
// and a compare flag telling the sequencer the final lane is selected.
module mux_scan_index_ctr
   import mux_scan_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic inc,
   input  sel_t first,
   input  sel_t last,
   output sel_t sel,
   output logic at_last
);

   sel_t sel_reg;
   sel_t last_reg;

   // Increment relies on natural SEL_W-bit overflow so 31 wraps to 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_reg  <= '0;
         last_reg <= '0;
      end else if (load) begin
         sel_reg  <= first;
         last_reg <= last;
      end else if (inc) begin
         sel_reg  <= sel_reg + 1'b1;
      end
   end

   assign sel     = sel_reg;
   assign at_last = (sel_reg == last_reg);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the selector across first..last (wrapping), samples one lane per index
// after SETTLE wait cycles, and hands the packed word out via valid/ready.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int unsigned SETTLE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  sel_t             first_i,
   input  sel_t             last_i,
   output sel_t             sel_o,
   input  lane_t            mux_out_i,
   output logic             busy_o,
   output logic [RES_W-1:0] result_o,
   output cnt_t             count_o,
   output logic             result_valid_o,
   input  logic             result_ready_i
);

   localparam settle_t SETTLE_INIT = settle_t'(SETTLE);

   scan_state_t state_reg, state_next;
   settle_t     settle_reg, settle_next;
   cnt_t        count_reg, count_next;
   logic        valid_reg, valid_next;
   logic        busy_reg, busy_next;

   logic ctr_load, ctr_inc, sample_en, clear_result;
   sel_t sel;
   logic at_last;

   mux_scan_index_ctr u_index_ctr (
      .clk     (clk),
      .reset   (reset),
      .load    (ctr_load),
      .inc     (ctr_inc),
      .first   (first_i),
      .last    (last_i),
      .sel     (sel),
      .at_last (at_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_i) state_next = SCAN;
         SCAN:    if (settle_reg == '0 && at_last) state_next = DONE;
         DONE:    if (valid_reg && result_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      settle_next  = settle_reg;
      count_next   = count_reg;
      valid_next   = valid_reg;
      ctr_load     = 1'b0;
      ctr_inc      = 1'b0;
      sample_en    = 1'b0;
      clear_result = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               ctr_load     = 1'b1;
               clear_result = 1'b1;
               count_next   = '0;
               settle_next  = SETTLE_INIT;
            end
         end
         SCAN: begin
            if (settle_reg != '0) begin
               settle_next = settle_reg - 1'b1;
            end else begin
               // Exactly one sample per index, taken at the settle boundary.
               sample_en  = 1'b1;
               count_next = count_reg + 1'b1;
               if (at_last) begin
                  valid_next = 1'b1;
               end else begin
                  ctr_inc     = 1'b1;
                  settle_next = SETTLE_INIT;
               end
            end
         end
         DONE: begin
            if (valid_reg && result_ready_i) valid_next = 1'b0;
         end
         default: ;
      endcase
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         settle_reg <= '0;
         count_reg  <= '0;
         valid_reg  <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         settle_reg <= settle_next;
         count_reg  <= count_next;
         valid_reg  <= valid_next;
         busy_reg   <= busy_next;
      end
   end

   // Lanes not visited by the current scan stay at the zero set on start.
   for (genvar gi = 0; gi < NUM_INP; gi++) begin : g_lane
      lane_t lane_reg;
      always_ff @(posedge clk) begin
         if (reset || clear_result)
            lane_reg <= '0;
         else if (sample_en && sel == sel_t'(gi))
            lane_reg <= mux_out_i;
      end
      assign result_o[DATA_W*gi +: DATA_W] = lane_reg;
   end

   assign sel_o          = sel;
   assign busy_o         = busy_reg;
   assign count_o        = count_reg;
   assign result_valid_o = valid_reg;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: two sequencer instances (SETTLE=0 and SETTLE=3) with a
// scoreboard queue checked by a monitor on each rising result_valid_o.
module tb_mux_scan_sequencer;
   import mux_scan_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic             start [2];
   sel_t             first [2];
   sel_t             last  [2];
   sel_t             sel   [2];
   lane_t            mux   [2];
   logic             busy  [2];
   logic [RES_W-1:0] res   [2];
   cnt_t             cnt   [2];
   logic             vld   [2];
   logic             rdy   [2];
   logic             pv    [2];
   logic             corrupt12;

   mux_scan_sequencer #(.SETTLE(0)) dut0 (
      .clk(clk), .reset(reset), .start_i(start[0]), .first_i(first[0]), .last_i(last[0]),
      .sel_o(sel[0]), .mux_out_i(mux[0]), .busy_o(busy[0]), .result_o(res[0]),
      .count_o(cnt[0]), .result_valid_o(vld[0]), .result_ready_i(rdy[0])
   );

   mux_scan_sequencer #(.SETTLE(3)) dut3 (
      .clk(clk), .reset(reset), .start_i(start[1]), .first_i(first[1]), .last_i(last[1]),
      .sel_o(sel[1]), .mux_out_i(mux[1]), .busy_o(busy[1]), .result_o(res[1]),
      .count_o(cnt[1]), .result_valid_o(vld[1]), .result_ready_i(rdy[1])
   );

   function automatic lane_t model(sel_t s);
      return s[1:0] ^ s[3:2];
   endfunction

   // Instance 0 optionally feeds lane 11's value on lane 12; instance 1 forces lane 5 to 2'b10.
   always_comb begin
      mux[0] = (corrupt12 && sel[0] == 5'd12) ? model(5'd11) : model(sel[0]);
      mux[1] = (sel[1] == 5'd5) ? 2'b10 : model(sel[1]);
   end

   function automatic logic [63:0] full_exp(logic c);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 32; k++)
         r[2*k +: 2] = (c && k == 12) ? model(5'd11) : model(sel_t'(k));
      return r;
   endfunction

   typedef struct {
      int          d;
      logic [63:0] r;
      int          c;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   start_cyc [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (vld[d] && !pv[d]) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_valid: dut%0d result %0h with empty queue", d, res[d]);
            end else begin
               e = q.pop_front();
               check("dut_id", 64'(d), 64'(e.d));
               check("result", res[d], e.r);
               check("count", 64'(cnt[d]), 64'(e.c));
               check("latency", 64'(cyc - start_cyc[d]), 64'(e.lat));
               $display("txn dut%0d result=%h count=%0d latency=%0d", d, res[d], cnt[d], cyc - start_cyc[d]);
            end
         end
         pv[d] <= vld[d];
      end
   end

   task automatic start_scan(int d, sel_t f, sel_t l, logic [63:0] r, int c, int lat);
      q.push_back('{d, r, c, lat});
      first[d] = f;
      last[d]  = l;
      start[d] = 1'b1;
      @(posedge clk); #1;
      start_cyc[d] = cyc;
      start[d] = 1'b0;
      first[d] = ~f;
      last[d]  = ~l;
   endtask

   task automatic wait_valid(int d, int budget);
      int k;
      k = 0;
      while (!vld[d] && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      n_vec++;
      if (!vld[d]) begin
         n_err++;
         $display("FAIL valid_timeout: dut%0d valid 0 after %0d cycles, required 1", d, budget);
      end
   endtask

   task automatic handshake(int d);
      rdy[d] = 1'b1;
      @(posedge clk); #1;
      check("valid_drop", 64'(vld[d]), 64'd0);
      check("busy_drop", 64'(busy[d]), 64'd0);
   endtask

   task automatic check_idle_zero(int d);
      check("rst_sel", 64'(sel[d]), 64'd0);
      check("rst_busy", 64'(busy[d]), 64'd0);
      check("rst_result", res[d], 64'd0);
      check("rst_count", 64'(cnt[d]), 64'd0);
      check("rst_valid", 64'(vld[d]), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      corrupt12 = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; first[d] = '0; last[d] = '0; rdy[d] = 1'b1; pv[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) check_idle_zero(d);
      reset = 1'b0;

      // Full range scan
      start_scan(0, 5'd0, 5'd31, full_exp(1'b0), 32, 32);
      wait_valid(0, 40);
      handshake(0);

      // Wrap-around 30..1
      start_scan(0, 5'd30, 5'd1, 64'h1000_0000_0000_0004, 4, 4);
      check("wrap_sel0", 64'(sel[0]), 64'd30);
      @(posedge clk); #1;
      check("wrap_sel1", 64'(sel[0]), 64'd31);
      @(posedge clk); #1;
      check("wrap_sel2", 64'(sel[0]), 64'd0);
      @(posedge clk); #1;
      check("wrap_sel3", 64'(sel[0]), 64'd1);
      wait_valid(0, 10);
      handshake(0);

      // SETTLE=3 single lane
      start_scan(1, 5'd5, 5'd5, 64'h800, 1, 4);
      for (int i = 0; i < 4; i++) begin
         check("settle_sel", 64'(sel[1]), 64'd5);
         if (i < 3) begin
            check("settle_novalid", 64'(vld[1]), 64'd0);
            @(posedge clk); #1;
         end
      end
      wait_valid(1, 10);
      check("settle_sel_hold", 64'(sel[1]), 64'd5);
      handshake(1);

      // Backpressure with ignored start pulses
      rdy[0] = 1'b0;
      start_scan(0, 5'd3, 5'd4, 64'h1C0, 2, 2);
      wait_valid(0, 10);
      for (int i = 0; i < 10; i++) begin
         start[0] = (i == 4);
         first[0] = 5'd9;
         last[0]  = 5'd9;
         @(posedge clk); #1;
         start[0] = 1'b0;
         check("bp_valid", 64'(vld[0]), 64'd1);
         check("bp_result", res[0], 64'h1C0);
         check("bp_count", 64'(cnt[0]), 64'd2);
      end
      rdy[0] = 1'b1;
      start[0] = 1'b1;
      first[0] = 5'd7;
      last[0]  = 5'd7;
      @(posedge clk); #1;
      start[0] = 1'b0;
      check("hs_valid", 64'(vld[0]), 64'd0);
      check("hs_start_ignored", 64'(busy[0]), 64'd0);
      check("hs_result_kept", res[0], 64'h1C0);
      check("hs_count_kept", 64'(cnt[0]), 64'd2);
      start_scan(0, 5'd7, 5'd7, 64'h8000, 1, 1);
      wait_valid(0, 10);
      handshake(0);

      // Reset in place of the 7th sample
      first[0] = 5'd0;
      last[0]  = 5'd31;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("pre_reset_count", 64'(cnt[0]), 64'd6);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_idle_zero(0);
      start_scan(0, 5'd0, 5'd31, full_exp(1'b0), 32, 32);
      wait_valid(0, 40);
      handshake(0);

      // Lane 12 fed with lane 11's value
      corrupt12 = 1'b1;
      start_scan(0, 5'd0, 5'd31, full_exp(1'b1), 32, 32);
      wait_valid(0, 40);
      handshake(0);
      corrupt12 = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream/downstream companion to the 32:1 two-bit selector.
- Drives the selector's 5-bit select across a programmable index range.
- Samples the selector's 2-bit output at each index and packs the samples into a 64-bit result word.
- Returns the word to the bus side through a valid/ready handshake. Used for bulk readout and self-check of all selector lanes.

Parameters:
- SEL_W, 5: select width; number of lanes NUM_INP = 2**SEL_W.
- DATA_W, 2: width of each selector lane and of each sample.
- SETTLE, 0: extra wait cycles after each select change before sampling (0..15).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  request a scan; accepted only in IDLE.
- first_i  in  SEL_W  first index of scan, captured on accept.
- last_i  in  SEL_W  last index of scan, captured on accept.
- sel_o  out  SEL_W  select driven to the selector.
- mux_out_i  in  DATA_W  selector output for current sel_o.
- busy_o  out  1  high in SCAN and DONE.
- result_o  out  NUM_INP*DATA_W  packed samples; lane k at bits [DATA_W*k +: DATA_W].
- count_o  out  SEL_W+1  number of lanes sampled in current/last scan.
- result_valid_o  out  1  result_o/count_o valid.
- result_ready_i  in  1  consumer accepts result.

Behaviour:
- Reset values (sync reset, any state, including mid-scan):
  - state=IDLE.
  - sel_o=0, busy_o=0, result_o=0, count_o=0, result_valid_o=0.
  - settle counter=0.
- States: IDLE, SCAN, DONE. All outputs are registered.
- IDLE -> SCAN when start_i=1 at a clock edge. On that edge:
  - sel_o<=first_i; last_i is latched.
  - result_o<=0, count_o<=0, settle counter<=SETTLE.
- SCAN, settle counter != 0: decrement it; sel_o holds.
- SCAN, settle counter == 0, sample on this edge:
  - result_o lane sel_o <= mux_out_i; count_o<=count_o+1.
  - If sel_o==latched last: go to DONE and set result_valid_o<=1 on the same edge; sel_o holds.
  - Else: sel_o<=sel_o+1, mod NUM_INP, so 31 wraps to 0; settle counter<=SETTLE.
- Wrap-around: first>last scans first..31 then 0..last.
- first==last: exactly one sample.
- Full range: first=0, last=31 gives count_o=32.
- Latency: for n lanes, result_valid_o rises n*(SETTLE+1) cycles after the start edge.
- DONE: result_valid_o=1 and result_o/count_o stable until result_valid_o&&result_ready_i.
  - On the handshake edge: result_valid_o<=0, state<=IDLE. result_o and count_o keep their values until the next accepted start.
  - result_ready_i is ignored outside DONE.
- start_i in SCAN or DONE is ignored; no queuing. start_i on the same edge as the DONE handshake is ignored; it is accepted from the following IDLE cycle.
- first_i/last_i changes after accept have no effect on the running scan.
- Lanes outside the scanned range read 0 in result_o.

Decomposition:
- Shared package mux_scan_pkg holds:
  - constants SEL_W, DATA_W, NUM_INP, RES_W=NUM_INP*DATA_W;
  - typedef scan_state_t enum {IDLE, SCAN, DONE};
  - typedefs sel_t, lane_t.
- One sub-module is natural: mux_scan_index_ctr. It provides a wrapping SEL_W index register with load, increment and compare-to-last, and outputs at_last.
- Sample packing and the FSM stay in the top.

Test Plan:
- Bench model mux_out_i = sel_o[1:0] XOR sel_o[3:2], SETTLE=0; start first=0, last=31. Required: result_valid_o exactly 32 cycles after the start edge, count_o=32, every lane k equals model(k).
- first=30, last=1 -> sel_o sequence 30,31,0,1; count_o=4; lanes 2..29 read 0; valid 4 cycles after the start edge.
- SETTLE=3, first=last=5, model lane 5=2'b10 -> sel_o=5 for 4 cycles; valid at cycle 4; result_o[11:10]=2'b10; count_o=1.
- Backpressure: hold result_ready_i=0 for 10 cycles in DONE and pulse start_i -> valid stays 1, result stable, start ignored; ready=1 -> valid 0 the next cycle, IDLE; a later start_i is accepted.
- Assert reset at the 7th sample of a 0..31 scan -> next cycle sel_o=0, busy_o=0, result_o=0, count_o=0, valid=0; a new scan completes correctly.
- Sample-integrity check: bench model forces lane 12 to hold the previous lane's value. Required: result_o lane 12 equals lane 11, proving the block samples mux_out_i exactly once per index at the settle boundary.
